// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: default widths, reset and
// exception vectors, and the next-PC source encoding.
package pc_pkg;

  // Default datapath widths.
  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned TGT_W_DEF = 26;
  localparam int unsigned OFF_W_DEF = 16;

  // Default vectors; the exception vector only matters when exceptions are built in.
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0040;

  // Which source feeds the PC register on the next edge.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_RET,
    SRC_EXC
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Push writes at the write pointer and advances
// it; pop retreats it. A push while full overwrites the oldest entry and sets the
// sticky overflow flag; a pop while empty sets the sticky underflow flag. Push and
// pop together replace the top entry, or act as a push (with underflow) if empty.
module pc_ras #(
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned W         = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     stack_q [RAS_DEPTH];
  logic [W-1:0]     stack_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Top of stack sits one below the write pointer; depth is a power of two so
  // the pointer wraps naturally.
  always_comb begin
    top_idx = ptr_q - PTR_W'(1);
    top     = stack_q[top_idx];
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_W'(RAS_DEPTH));
    ovf     = ovf_q;
    unf     = unf_q;
  end

  // Next-state for entries, pointer, count and sticky flags.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case ({push, pop})
      2'b10: begin
        stack_d[ptr_q] = push_data;
        ptr_d          = ptr_q + PTR_W'(1);
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          ptr_d = ptr_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      2'b11: begin
        if (empty) begin
          stack_d[ptr_q] = push_data;
          ptr_d          = ptr_q + PTR_W'(1);
          cnt_d          = CNT_W'(1);
          unf_d          = 1'b1;
        end else begin
          stack_d[top_idx] = push_data;
        end
      end
      default: ;
    endcase
  end

  // Stack state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      stack_q <= stack_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Registered program-counter unit for a word-addressed single-cycle MIPS core.
// Picks the next PC by priority (exception, stall, return, jr, jump, branch,
// sequential) and keeps a return-address stack for jal / jr $ra pairs.
// Optional exception support is built when PC_SEQ_UNIT_EXC_EN is defined.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_W_DEF,
  parameter int unsigned     TGT_W     = TGT_W_DEF,
  parameter int unsigned     OFF_W     = OFF_W_DEF,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PC_SEQ_UNIT_EXC_EN
  input  logic              exc,
  output logic [PC_W-1:0]   epc,
  output logic              exc_active,
`endif
  input  logic              stall,
  input  logic              br_taken,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              jump,
  input  logic [TGT_W-1:0]  jtarget,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_addr,
  input  logic              call,
  input  logic              ret,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus1,
  output logic [PC_W-1:0]   link_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] br_off_ext;
  logic [PC_W-1:0] ras_top;
  logic            hold;
  logic            exc_req;
  logic            ras_push;
  logic            ras_pop;
  pc_src_e         src;

`ifdef PC_SEQ_UNIT_EXC_EN
  logic [PC_W-1:0] epc_q, epc_d;
  logic            exc_active_q;

  assign exc_req    = exc;
  assign epc        = epc_q;
  assign exc_active = exc_active_q;
`else
  assign exc_req = 1'b0;
`endif

  // Sequential address and link value follow the registered PC.
  always_comb begin
    pc_plus1   = pc_q + PC_W'(1);
    link_addr  = pc_plus1;
    pc         = pc_q;
    br_off_ext = {{(PC_W - OFF_W){br_off[OFF_W-1]}}, br_off};
  end

  // Source select: exception outranks everything, stall freezes PC and RAS.
  always_comb begin
    src  = SRC_SEQ;
    hold = stall & ~exc_req;
    if (exc_req) begin
      src = SRC_EXC;
    end else if (ret) begin
      src = SRC_RET;
    end else if (jr) begin
      src = SRC_JR;
    end else if (jump) begin
      src = SRC_J;
    end else if (br_taken) begin
      src = SRC_BR;
    end
    // RAS only moves when the PC itself advances normally.
    ras_push = call & ~hold & ~exc_req;
    ras_pop  = ret & ~hold & ~exc_req;
  end

  // Target mux and next-PC.
  always_comb begin
    target = pc_plus1;
    unique case (src)
      SRC_EXC: target = EXC_VEC;
      SRC_RET: target = ras_empty ? jr_addr : ras_top;
      SRC_JR:  target = jr_addr;
      SRC_J:   target = {pc_plus1[PC_W-1:TGT_W], jtarget};
      SRC_BR:  target = pc_plus1 + br_off_ext;
      default: target = pc_plus1;
    endcase
    pc_d = hold ? pc_q : target;
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_SEQ_UNIT_EXC_EN
  // Exception PC captures the faulting PC; active flag marks the cycle after.
  always_comb begin
    epc_d = exc_req ? pc_q : epc_q;
  end

  // Exception state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q        <= '0;
      exc_active_q <= 1'b0;
    end else begin
      epc_q        <= epc_d;
      exc_active_q <= exc_req;
    end
  end
`endif

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .W         (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: reset, branch/jump, call/return, RAS
// overflow/underflow, stall priority, wrap and (if built) exceptions.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, jump, jr, call, ret;
  logic [15:0] br_off;
  logic [25:0] jtarget;
  logic [31:0] jr_addr;
  logic [31:0] pc, pc_plus1, link_addr;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_SEQ_UNIT_EXC_EN
  logic        exc;
  logic [31:0] epc;
  logic        exc_active;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_seq_unit dut (
    .clk        (clk),
    .rst        (rst),
`ifdef PC_SEQ_UNIT_EXC_EN
    .exc        (exc),
    .epc        (epc),
    .exc_active (exc_active),
`endif
    .stall      (stall),
    .br_taken   (br_taken),
    .br_off     (br_off),
    .jump       (jump),
    .jtarget    (jtarget),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .call       (call),
    .ret        (ret),
    .pc         (pc),
    .pc_plus1   (pc_plus1),
    .link_addr  (link_addr),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jump = 0; jr = 0; call = 0; ret = 0;
    br_off = '0; jtarget = '0; jr_addr = '0;
`ifdef PC_SEQ_UNIT_EXC_EN
    exc = 0;
`endif
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle();
    jr = 1; jr_addr = addr;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_plus1", pc_plus1, 32'h1);
    check("rst_link", link_addr, 32'h1);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_ovf", ras_ovf, 0);
    check("rst_unf", ras_unf, 0);
    rst = 0;

    // Async reset mid-run.
    go_to(32'h25);
    check("jr_0x25", pc, 32'h25);
    #2 rst = 1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_empty", ras_empty, 1);
    #1 rst = 0;
    check("seq0", pc, 32'h0);
    step(); check("seq1", pc, 32'h1);
    step(); check("seq2", pc, 32'h2);
    step(); check("seq3", pc, 32'h3);

    // Branches.
    go_to(32'h10);
    br_taken = 1; br_off = 16'hFFFC;
    step(); idle();
    check("br_neg", pc, 32'h0D);
    br_taken = 1; br_off = 16'h0005;
    step(); idle();
    check("br_pos", pc, 32'h13);

    // Jumps keep upper bits of pc_plus1; jump beats branch.
    go_to(32'h0400_0010);
    jump = 1; jtarget = 26'h123;
    step(); idle();
    check("jump", pc, 32'h0400_0123);
    jump = 1; jtarget = 26'h200; br_taken = 1; br_off = 16'h0001;
    step(); idle();
    check("jump_over_br", pc, 32'h0400_0200);

    // Call / return.
    go_to(32'h8);
    jump = 1; call = 1; jtarget = 26'h40;
    step(); idle();
    check("jal_pc", pc, 32'h40);
    check("jal_nonempty", ras_empty, 0);
    ret = 1; jr_addr = 32'hDEAD;
    step(); idle();
    check("ret_pc", pc, 32'h9);
    check("ret_empty", ras_empty, 1);

    // Overflow: push 0x11..0x15 into a 4-deep stack.
    go_to(32'h10);
    for (int i = 0; i < 5; i++) begin
      call = 1; jr = 1; jr_addr = 32'h11 + i;
      step(); idle();
      if (i == 3) begin
        check("full_at_4", ras_full, 1);
        check("no_ovf_at_4", ras_ovf, 0);
      end
    end
    check("ovf_set", ras_ovf, 1);
    check("ovf_full", ras_full, 1);
    for (int i = 0; i < 4; i++) begin
      ret = 1; jr_addr = 32'hDEAD;
      step(); idle();
      check($sformatf("pop%0d", i), pc, 32'h15 - i);
    end
    check("unf_clear", ras_unf, 0);
    ret = 1; jr_addr = 32'hBEEF;
    step(); idle();
    check("unf_pc", pc, 32'hBEEF);
    check("unf_set", ras_unf, 1);
    check("unf_empty", ras_empty, 1);
    check("ovf_sticky", ras_ovf, 1);

    // Flags clear only on reset.
    #2 rst = 1;
    #2 rst = 0;
    check("flags_clr_ovf", ras_ovf, 0);
    check("flags_clr_unf", ras_unf, 0);

    // Stall beats jump+call; call+ret replaces top.
    go_to(32'h2F);
    call = 1; jr = 1; jr_addr = 32'h50;
    step(); idle();
    check("push30_pc", pc, 32'h50);
    stall = 1; jump = 1; call = 1; jtarget = 26'h99;
    step(); idle();
    check("stall_pc", pc, 32'h50);
    check("stall_empty", ras_empty, 0);
    check("stall_full", ras_full, 0);
    call = 1; ret = 1; jr_addr = 32'hDEAD;
    step(); idle();
    check("callret_pc", pc, 32'h30);
    ret = 1; jr_addr = 32'hDEAD;
    step(); idle();
    check("new_top", pc, 32'h51);
    check("count_kept", ras_empty, 1);
    check("no_unf", ras_unf, 0);

    // Wrap.
    go_to(32'hFFFF_FFFF);
    check("wrap_plus1", pc_plus1, 32'h0);
    step();
    check("wrap_pc", pc, 32'h0);

`ifdef PC_SEQ_UNIT_EXC_EN
    go_to(32'h77);
    exc = 1; stall = 1;
    step(); idle();
    check("exc_pc", pc, 32'h40);
    check("exc_epc", epc, 32'h77);
    check("exc_active_hi", exc_active, 1);
    step();
    check("exc_active_lo", exc_active, 0);
    check("exc_after", pc, 32'h41);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Registered program-counter unit for the single-cycle MIPS datapath; replaces the combinational increment and jump-splice logic.
- Owns the PC register and computes next-PC from a priority of sources: exception, stall, return, jump-register, jump, branch, sequential.
- Contains a return-address stack (RAS) so `jal`/`jr $ra` pairs resolve without a register-file read.
- PC is word-addressed: sequential step is +1.

Parameters:
- PC_W, 32, PC width in bits.
- TGT_W, 26, jump target field width; upper PC_W-TGT_W bits come from pc_plus1.
- OFF_W, 16, branch offset width, sign-extended to PC_W.
- RAS_DEPTH, 4, RAS entries (power of two, ≥2).
- RESET_VEC, 0, PC value loaded on reset.
- EXC_VEC, 32'h0000_0040, exception target (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- br_taken  in  1  take branch.
- br_off  in  OFF_W  signed branch word offset.
- jump  in  1  direct jump.
- jtarget  in  TGT_W  jump target field.
- jr  in  1  jump to jr_addr.
- jr_addr  in  PC_W  register-sourced target.
- call  in  1  push pc_plus1 onto the RAS (qualifies jump or jr).
- ret  in  1  pop the RAS and use its top as target.
- pc  out  PC_W  current PC (registered).
- pc_plus1  out  PC_W  pc+1, combinational.
- link_addr  out  PC_W  equals pc_plus1; the `jal` writeback value.
- ras_empty  out  1  RAS count is 0.
- ras_full  out  1  RAS count equals RAS_DEPTH.
- ras_ovf  out  1  sticky: a push occurred while the RAS was full.
- ras_unf  out  1  sticky: a ret occurred while the RAS was empty.

Behaviour:
- Reset (async, any time, including mid-stall):
  - pc=RESET_VEC.
  - RAS count=0, write pointer=0.
  - ras_ovf=0, ras_unf=0.
  - Hence ras_empty=1, ras_full=0.
  - No other outputs are registered.
- Latency: next-PC is computed combinationally and loaded on the following rising edge. pc_plus1 and link_addr follow pc in the same cycle.
- Next-PC priority, highest first:
  1. stall: pc holds; RAS is unchanged; flags are unchanged.
  2. ret: target is the RAS top. If the RAS is empty, target is jr_addr, ras_unf is set, and the count stays 0.
  3. jr: target is jr_addr.
  4. jump: target is {pc_plus1[PC_W-1:TGT_W], jtarget}.
  5. br_taken: target is pc_plus1 + sign_extend(br_off).
  6. Otherwise: target is pc_plus1.
- Lower-priority requests are ignored when a higher-priority one is asserted.
- Arithmetic: all additions are modulo 2^PC_W. PC=all-ones wraps to 0. A negative offset wraps below 0.
- RAS operation, only when stall=0:
  - call=1, ret=0: write pc_plus1 at the pointer, advance the pointer mod RAS_DEPTH, count++.
    - If full, overwrite the oldest entry (circular); count stays at RAS_DEPTH and ras_ovf is set.
  - ret=1, call=0: retreat the pointer and count--, unless empty (see priority item 2).
  - call=1, ret=1: replace the top entry with pc_plus1; pointer and count are unchanged.
    - Next-PC uses the old top.
    - If empty, this behaves as a push and ras_unf is set.
  - call without jump or jr is legal and is still a push.
- Flags ras_ovf and ras_unf clear only on reset.

Optional Feature:
- Macro: PC_SEQ_UNIT_EXC_EN.
- With the macro defined, the following are added:
  - Input exc (1 bit).
  - Outputs epc (PC_W bits) and exc_active (1 bit, registered).
- exc=1 has priority over stall:
  - Next pc=EXC_VEC.
  - epc captures the current pc.
  - exc_active=1 for one cycle.
  - The RAS is unchanged.
- Reset values: epc=0, exc_active=0.
- Without the macro: no exc, epc, or exc_active ports, and priority starts at stall.

Decomposition:
- Shared package pc_pkg holds:
  - Default widths: PC_W, TGT_W, OFF_W.
  - RESET_VEC and EXC_VEC constants.
  - A next-PC source enum: SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_RET, SRC_EXC.
- Sub-module pc_ras: circular stack with parameter RAS_DEPTH. It has push/pop inputs and outputs top, empty, full, ovf and unf.
- The top level holds the PC register and the priority mux.

Test Plan:
- Reset: assert rst mid-run with pc=0x25 → pc=0 immediately (async), ras_empty=1. Release with no controls → pc reads 0,1,2,3 on successive cycles.
- Branch/jump: pc=0x10, br_taken, br_off=16'hFFFC → next pc=0x0D. From pc=0x0400_0010, jump, jtarget=0x123 → pc=0x0400_0123 (top 6 bits from pc_plus1).
- Call/return: pc=0x8, jump+call, jtarget=0x40 → pc=0x40, top=0x9. Then ret with jr_addr=0xDEAD → pc=0x9, ras_empty=1.
- RAS overflow: 5 calls with depth 4, pushing 0x11..0x15 → ras_ovf=1, ras_full=1. Then 4 rets → pc sequence 0x15,0x14,0x13,0x12. A 5th ret → pc=jr_addr, ras_unf=1.
- Stall priority: stall together with jump+call → pc is unchanged and the RAS count is unchanged. Simultaneous call+ret with top=0x30, pc=0x50 → next pc=0x30, top becomes 0x51, count unchanged.
- Wrap/exception: pc=0xFFFF_FFFF → next pc=0. With PC_SEQ_UNIT_EXC_EN, exc+stall at pc=0x77 → pc=0x40, epc=0x77, exc_active pulses for one cycle.
